// File: rtl/sha256_nonce_scanner.sv
// -----------------------------------------------------------------------------
// sha256_nonce_scanner
//
// Work feeder and result checker for a fixed-latency double-SHA256 core.
// One work unit is accepted in IDLE; the block then drives one nonce per clock
// into the core (SCAN), waits for the pipeline to empty (DRAIN), and compares
// every returned hash against the target. Nonces whose hash is <= target are
// queued in a small FIFO behind a valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   work_valid/ready    work offer / accepted only in IDLE
//   work_midstate       midstate forwarded to the core on hash0
//   work_tail           96-bit header tail placed in data1[95:0]
//   work_target         256-bit unsigned target
//   work_nonce_start    first nonce issued
//   abort               cancel the current scan (ignored in IDLE)
//   hash0, data1        registered core inputs
//   hash2               final hash from the core, PIPE_LATENCY after data1
//   gold_valid/ready    golden-nonce FIFO handshake, gold_nonce is the head
//   busy, done          not IDLE / one-cycle end-of-scan pulse
//   overflow            sticky: a hit was dropped on a full FIFO
//   hashes_done         results checked in the current work unit (saturating)
// -----------------------------------------------------------------------------
module sha256_nonce_scanner #(
    parameter int PIPE_LATENCY = 128,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_tail,
    input  logic [255:0] work_target,
    input  logic [31:0]  work_nonce_start,
    input  logic         abort,
    output logic [255:0] hash0,
    output logic [511:0] data1,
    input  logic [255:0] hash2,
    output logic         gold_valid,
    input  logic         gold_ready,
    output logic [31:0]  gold_nonce,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [31:0]  hashes_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t         state;
    logic [31:0]    nonce;
    logic [31:0]    chk_nonce;
    logic [95:0]    tail_q;
    logic [255:0]   target_q;
    // Bit 0 lines up with the nonce currently on data1; bit PIPE_LATENCY lines
    // up with the cycle its hash is present on hash2.
    logic [PIPE_LATENCY:0] vld;

    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    logic aborting;
    logic issue;
    logic result_valid;
    logic hit;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic drain_last;

    // Abort outranks every other transition and also blanks the result that
    // would have been checked on the same edge.
    assign aborting     = abort && (state != IDLE);
    assign issue        = (state == SCAN) && !abort;
    assign result_valid = vld[PIPE_LATENCY] && !aborting;
    assign hit          = result_valid && (hash2 <= target_q);
    // Only the final in-flight result remains: this edge checks it.
    assign drain_last   = (state == DRAIN) && (vld[PIPE_LATENCY-1:0] == '0);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && gold_ready;
    // A pop on the same edge frees the slot the push needs; no empty bypass.
    assign push       = hit && (!fifo_full || pop);

    assign gold_valid = !fifo_empty;
    assign gold_nonce = mem[rd_ptr[AW-1:0]];
    assign work_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // races between the FSM, counters and the delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            nonce       <= '0;
            chk_nonce   <= '0;
            tail_q      <= '0;
            target_q    <= '0;
            vld         <= '0;
            hash0       <= '0;
            data1       <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            hashes_done <= '0;
        end else begin
            done <= 1'b0;

            if (aborting) vld <= '0;
            else          vld <= {vld[PIPE_LATENCY-1:0], issue};

            if (result_valid) begin
                chk_nonce <= chk_nonce + 32'd1;
                if (hashes_done != 32'hFFFF_FFFF) hashes_done <= hashes_done + 32'd1;
            end
            if (hit && !push) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (work_valid) begin
                        hash0       <= work_midstate;
                        tail_q      <= work_tail;
                        target_q    <= work_target;
                        nonce       <= work_nonce_start;
                        chk_nonce   <= work_nonce_start;
                        hashes_done <= '0;
                        overflow    <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        data1 <= {384'h0, nonce, tail_q};
                        // The last nonce is issued once; the counter never wraps.
                        if (nonce == 32'hFFFF_FFFF) state <= DRAIN;
                        else                        nonce <= nonce + 32'd1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (drain_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage is reset because gold_nonce reads the head slot
    // directly and must show 0 after reset; it is only a few words deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= chk_nonce;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_sha256_nonce_scanner.sv
// -----------------------------------------------------------------------------
// tb_sha256_nonce_scanner
//
// Drives sha256_nonce_scanner (PIPE_LATENCY=4, FIFO_DEPTH=4) against a
// behavioural core stub. A transaction-level reference model works out, from
// each work unit's start/target/abort point, which results arrive on which
// edge and which of them land in the golden FIFO; a monitor compares the DUT
// outputs every cycle and pops expected nonces on each handshake.
// -----------------------------------------------------------------------------
module tb_sha256_nonce_scanner;

    localparam int L = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_tail;
    logic [255:0] work_target;
    logic [31:0]  work_nonce_start;
    logic         abort;
    logic [255:0] hash0;
    logic [511:0] data1;
    logic [255:0] hash2;
    logic         gold_valid;
    logic         gold_ready;
    logic [31:0]  gold_nonce;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [31:0]  hashes_done;

    sha256_nonce_scanner #(.PIPE_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_tail(work_tail),
        .work_target(work_target), .work_nonce_start(work_nonce_start),
        .abort(abort), .hash0(hash0), .data1(data1), .hash2(hash2),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_nonce(gold_nonce),
        .busy(busy), .done(done), .overflow(overflow), .hashes_done(hashes_done)
    );

    always #5 clk = ~clk;

    // ---------------- core stub ----------------
    int          stub_mode = 0;
    logic [31:0] salt = 32'h0;
    logic [31:0] pipe [L];

    function automatic logic [255:0] stub_hash(input int mode, input logic [31:0] n,
                                               input logic [31:0] s);
        logic [31:0] w;
        w = (n * 32'h9E37_79B1) ^ s;
        case (mode)
            0:       return {224'h0, n};
            1:       return (n == 32'h10) ? 256'h0 : {224'h0, n | 32'h8000_0000};
            default: return {8{w}};
        endcase
    endfunction

    always @(posedge clk) begin
        pipe[0] <= data1[127:96];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign hash2 = stub_hash(stub_mode, pipe[L-1], salt);

    // ---------------- reference model ----------------
    typedef struct {int due; logic [31:0] nonce; bit hit;} result_t;
    result_t     pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped[$];

    int cyc = 0;
    int acc_edge = -1, iss_first = -1, iss_last = -1, done_edge = -1, abort_edge = -1;
    logic [31:0]  w_start = '0;
    logic [95:0]  w_tail = '0;
    logic [255:0] w_mid = '0;
    bit           m_busy = 0, m_done = 0, m_overflow = 0;
    logic [31:0]  m_hashes = '0, m_nonce = '0;
    logic [95:0]  m_tail = '0;
    logic [255:0] m_hash0 = '0;
    bit           in_reset = 1;

    always @(posedge clk) begin
        result_t r;
        cyc = cyc + 1;
        if (!in_reset) begin
            if (cyc == acc_edge) begin
                m_busy = 1; m_overflow = 0; m_hashes = '0; m_hash0 = w_mid;
            end
            if (iss_first >= 0 && cyc >= iss_first && cyc <= iss_last) begin
                m_nonce = w_start + 32'(cyc - iss_first);
                m_tail  = w_tail;
            end
            while (pending.size() > 0 && pending[0].due == cyc) begin
                r = pending.pop_front();
                if (m_hashes != 32'hFFFF_FFFF) m_hashes = m_hashes + 1;
                if (r.hit) begin
                    if (exp_q.size() < D) exp_q.push_back(r.nonce);
                    else                  m_overflow = 1;
                end
            end
            m_done = (cyc == done_edge);
            if (m_done || cyc == abort_edge) m_busy = 0;
        end
    end

    task automatic model_reset();
        pending.delete(); exp_q.delete();
        acc_edge = -1; iss_first = -1; iss_last = -1; done_edge = -1; abort_edge = -1;
        m_busy = 0; m_done = 0; m_overflow = 0; m_hashes = '0; m_nonce = '0;
        m_tail = '0; m_hash0 = '0;
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int done_cnt = 0;
    int data10_cyc = -1, gold_rise_cyc = -1;
    bit prev_gv = 0;

    initial forever begin
        @(negedge clk); #2;
        if (!in_reset) begin
            check("busy", busy, m_busy);
            check("work_ready", work_ready, !m_busy);
            check("done", done, m_done);
            check("overflow", overflow, m_overflow);
            check("hashes_done", hashes_done, m_hashes);
            check("hash0", hash0, m_hash0);
            check("data1", data1, {384'h0, m_nonce, m_tail});
            check("gold_valid", gold_valid, exp_q.size() != 0);
            if (done) done_cnt++;
            if (data1[127:96] == 32'h10 && data10_cyc < 0) data10_cyc = cyc;
            if (gold_valid && !prev_gv && gold_rise_cyc < 0) gold_rise_cyc = cyc;
            prev_gv = gold_valid;
            if (gold_valid && gold_ready) begin
                popped.push_back(gold_nonce);
                if (exp_q.size() > 0) check("gold_nonce", gold_nonce, exp_q.pop_front());
            end
        end
    end

    // gold_ready: 0 low, 1 high, 2 random, 3 driven by the test
    int rdy_mode = 0;
    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0: gold_ready = 1'b0;
            1: gold_ready = 1'b1;
            2: gold_ready = 1'($urandom % 2);
            default: ;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic begin_work(input logic [31:0] start, input logic [255:0] target,
                              input int n_abort, output int a);
        longint total;
        int     due;
        a = cyc + 1;
        total = (n_abort > 0) ? longint'(n_abort) : (64'h1_0000_0000 - longint'(start));
        w_start = start;
        w_tail  = {$urandom, $urandom, $urandom};
        w_mid   = {8{$urandom}};
        acc_edge = a; iss_first = a + 1; iss_last = a + int'(total);
        if (n_abort > 0) begin abort_edge = a + int'(total) + 1; done_edge = -1; end
        else             begin abort_edge = -1; done_edge = a + int'(total) + L + 1; end
        for (int k = 0; k < int'(total); k++) begin
            due = a + k + L + 2;
            if (n_abort == 0 || due < abort_edge)
                pending.push_back('{due, start + 32'(k),
                    stub_hash(stub_mode, start + 32'(k), salt) <= target});
        end
        work_midstate = w_mid; work_tail = w_tail; work_target = target;
        work_nonce_start = start; work_valid = 1'b1;
        @(negedge clk);
        work_valid = 1'b0;
    endtask

    task automatic finish_work();
        if (abort_edge > 0) begin
            while (cyc < abort_edge - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end else begin
            while (cyc < done_edge) @(negedge clk);
        end
    endtask

    task automatic check_reset_values();
        check("rst_hash0", hash0, 0);            check("rst_data1", data1, 0);
        check("rst_gold_nonce", gold_nonce, 0);  check("rst_hashes_done", hashes_done, 0);
        check("rst_gold_valid", gold_valid, 0);  check("rst_busy", busy, 0);
        check("rst_done", done, 0);              check("rst_overflow", overflow, 0);
        check("rst_work_ready", work_ready, 1);
    endtask

    initial begin
        int a;
        logic [255:0] t;
        rst = 1'b1; work_valid = 1'b0; abort = 1'b0; gold_ready = 1'b0;
        work_midstate = '0; work_tail = '0; work_target = '0; work_nonce_start = '0;
        #12 check_reset_values();
        @(negedge clk); rst = 1'b0; in_reset = 0;
        repeat (2) @(negedge clk);

        // FIFO fills with 0..3 while consumer stalls; 4 and 5 are dropped.
        rdy_mode = 0; stub_mode = 0; popped.delete();
        begin_work(32'h0, 256'd5, 20, a);
        finish_work();
        check("t1_overflow", overflow, 1);
        rdy_mode = 1;
        repeat (8) @(negedge clk);
        check("t1_pop_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) check("t1_pop_order", popped[i], i);

        // Top of nonce space: exactly four hits, no wrap, one done pulse.
        popped.delete(); done_cnt = 0;
        begin_work(32'hFFFF_FFFC, {256{1'b1}}, 0, a);
        finish_work();
        repeat (3) @(negedge clk);
        check("t2_pop_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            check("t2_pop_value", popped[i], 32'hFFFF_FFFC + 32'(i));
        check("t2_done_count", done_cnt, 1);
        check("t2_hashes_done", hashes_done, 4);
        check("t2_work_ready", work_ready, 1);

        // Single winner at 0x10; gold_valid rises L+1 cycles after it is issued.
        stub_mode = 1; popped.delete(); data10_cyc = -1; gold_rise_cyc = -1;
        begin_work(32'h0, 256'h0, 24, a);
        finish_work();
        repeat (4) @(negedge clk);
        check("t3_pop_count", popped.size(), 1);
        if (popped.size() > 0) check("t3_pop_value", popped[0], 32'h10);
        check("t3_gold_latency", gold_rise_cyc - data10_cyc, L + 1);

        // Abort two cycles into SCAN: in-flight hits are discarded, no done.
        stub_mode = 0; popped.delete(); done_cnt = 0;
        begin_work(32'h200, {256{1'b1}}, 2, a);
        finish_work();
        #3 check("t4_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t4_pop_count", popped.size(), 0);
        check("t4_done_count", done_cnt, 0);

        // Reset mid-scan with two entries queued.
        rdy_mode = 0;
        begin_work(32'h0, {256{1'b1}}, 50, a);
        while (cyc < a + L + 3) @(negedge clk);
        #3 check("t5_queued", gold_valid, 1);
        in_reset = 1; rst = 1'b1;
        #1 check_reset_values();
        model_reset();
        @(negedge clk); rst = 1'b0; in_reset = 0;
        repeat (2) @(negedge clk);

        // Full FIFO with a push and a pop on the same edge.
        rdy_mode = 3; gold_ready = 1'b0; popped.delete();
        begin_work(32'h100, 256'h104, 10, a);
        while (cyc < a + L + 5) @(negedge clk);
        gold_ready = 1'b1;
        @(negedge clk);
        gold_ready = 1'b0;
        finish_work();
        check("t6_overflow", overflow, 0);
        rdy_mode = 1;
        repeat (8) @(negedge clk);
        check("t6_pop_count", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("t6_pop_value", popped[i], 32'h100 + 32'(i));

        // Randomised work units, random consumer, stray abort/work pulses.
        stub_mode = 2; rdy_mode = 2;
        for (int it = 0; it < 8; it++) begin
            int n_ab;
            logic [31:0] st;
            salt = $urandom;
            for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
            n_ab = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, 30));
            st = (n_ab == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 30)) : $urandom;
            abort = 1'b1; @(negedge clk); abort = 1'b0;
            begin_work(st, t, n_ab, a);
            if (n_ab == 0 || n_ab >= 3) begin
                work_valid = 1'b1; work_nonce_start = $urandom; work_midstate = '1;
                @(negedge clk);
                work_valid = 1'b0;
            end
            finish_work();
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        rdy_mode = 1;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
